// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: function codes, ALU control codes,
// alu_op encodings and the multiplier FSM state type.
package alu_pkg;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_MUL = 3'b011;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLT = 6'b101010;
    localparam logic [5:0] FUNC_MUL = 6'b011000;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_exec_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, fixed
// WIDTH-cycle run. done/product are valid in the final iteration cycle.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplr_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_step_s;
    logic [CNT_W-1:0] cnt_r;
    logic             last_s;

    assign last_s     = (cnt_r == CNT_W'(1));
    assign acc_step_s = acc_r + (mplr_r[0] ? mcand_r : {WIDTH{1'b0}});
    assign busy       = (state_r == ST_MUL);
    assign product    = acc_step_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and completion decode; flush cancels without a done
    always_comb begin
        state_nx_s = state_r;
        done       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_nx_s = ST_MUL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_nx_s = ST_IDLE;
                end else if (last_s) begin
                    state_nx_s = ST_IDLE;
                    done       = 1'b1;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Operand load and one shift-add step per MUL cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r <= {WIDTH{1'b0}};
            mplr_r  <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (flush) begin
            cnt_r   <= {CNT_W{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            mcand_r <= a;
            mplr_r  <= b;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= CNT_W'(WIDTH);
        end else if (state_r == ST_MUL) begin
            acc_r   <= acc_step_s;
            mcand_r <= {mcand_r[WIDTH-2:0], 1'b0};
            mplr_r  <= {1'b0, mplr_r[WIDTH-1:1]};
            cnt_r   <= cnt_r - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute-stage ALU: alu_op/func decode, single-cycle ALU, iterative MUL with
// pipeline stall, flush, illegal-op reporting and registered result.
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [1:0]       alu_op_i,
    input  logic [5:0]       func_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [2:0]       alu_ctrl_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
);

    logic [2:0]       ctrl_s;
    logic             illegal_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             is_mul_s;
    logic             accept_s;
    logic             mul_start_s;
    logic             mul_busy_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_prod_s;
    logic [WIDTH-1:0] result_r;
    logic             done_r;
    logic             illegal_r;

    // Decode alu_op/func into the ALU control code; unknowns fall back to ADD
    always_comb begin
        ctrl_s    = CTRL_ADD;
        illegal_s = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: ctrl_s = CTRL_ADD;
            ALUOP_SUB: ctrl_s = CTRL_SUB;
            ALUOP_FUNC: begin
                case (func_i)
                    FUNC_ADD: ctrl_s = CTRL_ADD;
                    FUNC_SUB: ctrl_s = CTRL_SUB;
                    FUNC_AND: ctrl_s = CTRL_AND;
                    FUNC_OR:  ctrl_s = CTRL_OR;
                    FUNC_SLT: ctrl_s = CTRL_SLT;
                    FUNC_MUL: ctrl_s = CTRL_MUL;
                    default: begin
                        ctrl_s    = CTRL_ADD;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_s    = CTRL_ADD;
                illegal_s = 1'b1;
            end
        endcase
    end

    // Single-cycle ALU; MUL result comes from the iterative unit
    always_comb begin
        alu_res_s = data1_i + data2_i;
        case (ctrl_s)
            CTRL_AND: alu_res_s = data1_i & data2_i;
            CTRL_OR:  alu_res_s = data1_i | data2_i;
            CTRL_ADD: alu_res_s = data1_i + data2_i;
            CTRL_SUB: alu_res_s = data1_i - data2_i;
            CTRL_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            default:  alu_res_s = data1_i + data2_i;
        endcase
    end

    assign is_mul_s    = (ctrl_s == CTRL_MUL);
    assign accept_s    = valid_i & ~mul_busy_s & ~flush_i;
    assign mul_start_s = accept_s & is_mul_s;

    // Stall covers the accept cycle combinationally; never raised under flush or reset
    assign stall_o     = ~rst_i & ~flush_i & (mul_busy_s | mul_start_s);
    assign alu_ctrl_o  = ctrl_s;
    assign done_o      = done_r;
    assign result_o    = result_r;
    assign illegal_o   = illegal_r;

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (mul_start_s),
        .flush   (flush_i),
        .a       (data1_i),
        .b       (data2_i),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Output registers; result holds between done pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_r  <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else if (mul_done_s) begin
            result_r  <= mul_prod_s;
            done_r    <= 1'b1;
            illegal_r <= 1'b0;
        end else if (accept_s && !is_mul_s) begin
            result_r  <= alu_res_s;
            done_r    <= 1'b1;
            illegal_r <= illegal_s;
        end else begin
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end
    end

endmodule
